// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM pipeline stage with a 256 x 32-bit data memory and
// the MEM/WB pipeline register.
// - Word and byte stores (little-endian lanes). Loads read the memory
//   combinationally, so the load data reaches MEM/WB one edge after the load.
// - MEM/WB priority: reset > flush > stall > normal.
// - Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, a word access
//   with ALU_Result[1:0] != 0 is trapped and flagged on out_MEM_Misaligned.
//   When undefined, the low address bits are ignored for word accesses.
module mem_stage_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_MEM_Store_Byte,
  input  logic        in_MEM_Mem_Write,
  input  logic        in_MEM_Mem_Read,
  input  logic        in_MEM_Reg_Write,
  input  logic        in_MEM_Mem_to_Reg,
  input  logic [4:0]  in_MEM_Write_Reg,
  input  logic [31:0] in_MEM_ALU_Result,
  input  logic [31:0] in_MEM_Write_Data,
  input  logic        in_stall,
  input  logic        in_flush,
  output logic        out_MEM_WB_Reg_Write,
  output logic        out_MEM_WB_Mem_to_Reg,
  output logic [4:0]  out_MEM_WB_Write_Reg,
  output logic [31:0] out_MEM_WB_ALU_Result,
  output logic [31:0] out_MEM_WB_Read_Data,
  output logic        out_MEM_WB_Valid,
  output logic [15:0] out_MEM_Store_Count,
  output logic        out_MEM_Misaligned
);

  // Data memory; contents are never reset.
  logic [31:0] mem [0:255];

  logic [7:0]  mem_index;
  logic [1:0]  byte_lane;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  lane_en;
  logic        misalign;
  logic        advance;
  logic        mem_we;

  // MEM/WB pipeline register state.
  logic        reg_write_reg;
  logic        mem_to_reg_reg;
  logic [4:0]  write_reg_reg;
  logic [31:0] alu_result_reg;
  logic [31:0] read_data_reg;
  logic        valid_reg;
  logic [15:0] store_count_reg;

  // Address bits [31:10] are dropped, so the memory aliases every 1 KB.
  assign mem_index = in_MEM_ALU_Result[9:2];
  assign byte_lane = in_MEM_ALU_Result[1:0];

  // Asynchronous read: the word is available in the same cycle as the
  // address, and a simultaneous store still returns the pre-write word.
  assign mem_rdata = mem[mem_index];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (in_MEM_Mem_Read | in_MEM_Mem_Write) &
                    ~in_MEM_Store_Byte & (byte_lane != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A cycle that updates MEM/WB with the incoming instruction.
  assign advance = ~in_flush & ~in_stall;

  // A store commits only out of reset, in a normal cycle, and untrapped.
  // The same strobe drives the store counter.
  assign mem_we = rst_n & advance & in_MEM_Mem_Write & ~misalign;

  // Build the write word lane by lane: a word store replaces every lane, a
  // byte store replaces only the addressed lane and keeps the others.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = ~in_MEM_Store_Byte | (byte_lane == 2'(gi));
      assign mem_wdata[gi*8 +: 8] =
        !lane_en[gi]      ? mem_rdata[gi*8 +: 8] :
        in_MEM_Store_Byte ? in_MEM_Write_Data[7:0] :
                            in_MEM_Write_Data[gi*8 +: 8];
    end
  endgenerate

  // Memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_index] <= mem_wdata;
    end
  end

  // MEM/WB register: flush loads a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      write_reg_reg  <= 5'd0;
      alu_result_reg <= 32'h0;
      read_data_reg  <= 32'h0;
      valid_reg      <= 1'b0;
    end else if (in_flush) begin
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      write_reg_reg  <= 5'd0;
      alu_result_reg <= 32'h0;
      read_data_reg  <= 32'h0;
      valid_reg      <= 1'b0;
    end else if (!in_stall) begin
      reg_write_reg  <= in_MEM_Reg_Write & ~misalign;
      mem_to_reg_reg <= in_MEM_Mem_to_Reg;
      write_reg_reg  <= in_MEM_Write_Reg;
      alu_result_reg <= in_MEM_ALU_Result;
      read_data_reg  <= (in_MEM_Mem_Read && !misalign) ? mem_rdata : 32'h0;
      valid_reg      <= 1'b1;
    end
  end

  // Committed-store counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_count_reg <= 16'd0;
    end else if (mem_we) begin
      store_count_reg <= store_count_reg + 16'd1;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_reg;

  // Trap flag follows the same flush/stall rules as the MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_reg <= 1'b0;
    end else if (in_flush) begin
      misaligned_reg <= 1'b0;
    end else if (!in_stall) begin
      misaligned_reg <= misalign;
    end
  end

  assign out_MEM_Misaligned = misaligned_reg;
`else
  assign out_MEM_Misaligned = 1'b0;
`endif

  assign out_MEM_WB_Reg_Write  = reg_write_reg;
  assign out_MEM_WB_Mem_to_Reg = mem_to_reg_reg;
  assign out_MEM_WB_Write_Reg  = write_reg_reg;
  assign out_MEM_WB_ALU_Result = alu_result_reg;
  assign out_MEM_WB_Read_Data  = read_data_reg;
  assign out_MEM_WB_Valid      = valid_reg;
  assign out_MEM_Store_Count   = store_count_reg;

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: scoreboard bench for mem_stage_access. Each driven
// transaction pushes its expected MEM/WB state into a queue; the entry is
// popped and compared just after the following rising edge.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_MEM_Store_Byte;
  logic        in_MEM_Mem_Write;
  logic        in_MEM_Mem_Read;
  logic        in_MEM_Reg_Write;
  logic        in_MEM_Mem_to_Reg;
  logic [4:0]  in_MEM_Write_Reg;
  logic [31:0] in_MEM_ALU_Result;
  logic [31:0] in_MEM_Write_Data;
  logic        in_stall;
  logic        in_flush;
  logic        out_MEM_WB_Reg_Write;
  logic        out_MEM_WB_Mem_to_Reg;
  logic [4:0]  out_MEM_WB_Write_Reg;
  logic [31:0] out_MEM_WB_ALU_Result;
  logic [31:0] out_MEM_WB_Read_Data;
  logic        out_MEM_WB_Valid;
  logic [15:0] out_MEM_Store_Count;
  logic        out_MEM_Misaligned;

  always #5 clk = ~clk;

  mem_stage_access dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_MEM_Store_Byte     (in_MEM_Store_Byte),
    .in_MEM_Mem_Write      (in_MEM_Mem_Write),
    .in_MEM_Mem_Read       (in_MEM_Mem_Read),
    .in_MEM_Reg_Write      (in_MEM_Reg_Write),
    .in_MEM_Mem_to_Reg     (in_MEM_Mem_to_Reg),
    .in_MEM_Write_Reg      (in_MEM_Write_Reg),
    .in_MEM_ALU_Result     (in_MEM_ALU_Result),
    .in_MEM_Write_Data     (in_MEM_Write_Data),
    .in_stall              (in_stall),
    .in_flush              (in_flush),
    .out_MEM_WB_Reg_Write  (out_MEM_WB_Reg_Write),
    .out_MEM_WB_Mem_to_Reg (out_MEM_WB_Mem_to_Reg),
    .out_MEM_WB_Write_Reg  (out_MEM_WB_Write_Reg),
    .out_MEM_WB_ALU_Result (out_MEM_WB_ALU_Result),
    .out_MEM_WB_Read_Data  (out_MEM_WB_Read_Data),
    .out_MEM_WB_Valid      (out_MEM_WB_Valid),
    .out_MEM_Store_Count   (out_MEM_Store_Count),
    .out_MEM_Misaligned    (out_MEM_Misaligned)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  write_reg;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [15:0] count;
    logic        mis;
  } exp_t;

  exp_t        state;
  exp_t        sb_q[$];
  logic [31:0] ref_mem [256];
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(out_MEM_WB_Valid), 32'h0);
    check_eq({tag, "_regwr"}, 32'(out_MEM_WB_Reg_Write), 32'h0);
    check_eq({tag, "_m2r"},   32'(out_MEM_WB_Mem_to_Reg), 32'h0);
    check_eq({tag, "_wreg"},  32'(out_MEM_WB_Write_Reg), 32'h0);
    check_eq({tag, "_alu"},   out_MEM_WB_ALU_Result, 32'h0);
    check_eq({tag, "_rdata"}, out_MEM_WB_Read_Data, 32'h0);
    check_eq({tag, "_count"}, 32'(out_MEM_Store_Count), 32'h0);
    check_eq({tag, "_mis"},   32'(out_MEM_Misaligned), 32'h0);
  endtask

  // Drive one transaction at posedge+1, predict, then compare at next posedge+1.
  task automatic step(input logic sb, input logic wr, input logic rd, input logic rw,
                      input logic m2r, input logic [4:0] wreg, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic stall, input logic flush,
                      input bit verbose);
    exp_t       nxt;
    exp_t       e;
    logic       trap;
    logic [7:0] idx;
    in_MEM_Store_Byte = sb;
    in_MEM_Mem_Write  = wr;
    in_MEM_Mem_Read   = rd;
    in_MEM_Reg_Write  = rw;
    in_MEM_Mem_to_Reg = m2r;
    in_MEM_Write_Reg  = wreg;
    in_MEM_ALU_Result = addr;
    in_MEM_Write_Data = wdata;
    in_stall          = stall;
    in_flush          = flush;
    idx  = addr[9:2];
    trap = TRAP_EN && (rd || wr) && !sb && (addr[1:0] != 2'b00);
    nxt  = state;
    if (flush) begin
      nxt.valid = 1'b0; nxt.reg_write = 1'b0; nxt.mem_to_reg = 1'b0;
      nxt.write_reg = 5'd0; nxt.alu = 32'h0; nxt.rdata = 32'h0; nxt.mis = 1'b0;
    end else if (!stall) begin
      nxt.valid      = 1'b1;
      nxt.reg_write  = rw && !trap;
      nxt.mem_to_reg = m2r;
      nxt.write_reg  = wreg;
      nxt.alu        = addr;
      nxt.rdata      = (rd && !trap) ? ref_mem[idx] : 32'h0;
      nxt.mis        = trap;
      if (wr && !trap) begin
        if (sb) ref_mem[idx][addr[1:0]*8 +: 8] = wdata[7:0];
        else    ref_mem[idx] = wdata;
        nxt.count = state.count + 16'd1;
      end
    end
    state = nxt;
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("valid", 32'(out_MEM_WB_Valid), 32'(e.valid));
    check_eq("reg_write", 32'(out_MEM_WB_Reg_Write), 32'(e.reg_write));
    check_eq("mem_to_reg", 32'(out_MEM_WB_Mem_to_Reg), 32'(e.mem_to_reg));
    check_eq("write_reg", 32'(out_MEM_WB_Write_Reg), 32'(e.write_reg));
    check_eq("alu_result", out_MEM_WB_ALU_Result, e.alu);
    check_eq("read_data", out_MEM_WB_Read_Data, e.rdata);
    check_eq("store_count", 32'(out_MEM_Store_Count), 32'(e.count));
    check_eq("misaligned", 32'(out_MEM_Misaligned), 32'(e.mis));
    if (verbose)
      $display("txn wr=%0b rd=%0b sb=%0b addr=%h wdata=%h stall=%0b flush=%0b -> valid=%0b rdata=%h count=%0d mis=%0b",
               wr, rd, sb, addr, wdata, stall, flush, out_MEM_WB_Valid,
               out_MEM_WB_Read_Data, out_MEM_Store_Count, out_MEM_Misaligned);
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, addr, data, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic lw(input logic [31:0] addr, input logic [4:0] rd_reg);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rd_reg, addr, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [15:0] start_count;
    logic [31:0] addr;
    int          op;
    state = '{default: '0};
    rst_n = 1'b0;
    in_MEM_Store_Byte = 0; in_MEM_Mem_Write = 0; in_MEM_Mem_Read = 0;
    in_MEM_Reg_Write = 0; in_MEM_Mem_to_Reg = 0; in_MEM_Write_Reg = 0;
    in_MEM_ALU_Result = 0; in_MEM_Write_Data = 0; in_stall = 0; in_flush = 0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("release_waits_edge", 32'(out_MEM_WB_Valid), 32'h0);
    #1;
    while (!clk) #1;
    @(posedge clk);
    #1;
    // Nothing was clocked with rst_n high and inputs idle except that edge:
    // it loaded an idle normal cycle.
    state.valid = 1'b1;
    check_eq("idle_valid", 32'(out_MEM_WB_Valid), 32'h1);

    // Word store then load.
    sw(32'h10, 32'hDEADBEEF);
    lw(32'h10, 5'd3);
    check_eq("sw_lw_data", out_MEM_WB_Read_Data, 32'hDEADBEEF);
    check_eq("sw_lw_count", 32'(out_MEM_Store_Count), 32'd1);

    // Byte lane store.
    sw(32'h20, 32'h11223344);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h22, 32'h000000AA, 1'b0, 1'b0, 1'b1);
    lw(32'h20, 5'd4);
    check_eq("byte_lane", out_MEM_WB_Read_Data, 32'h11AA3344);

    // Address wrap at 1 KB.
    sw(32'h400, 32'h5);
    lw(32'h000, 5'd5);
    check_eq("wrap", out_MEM_WB_Read_Data, 32'h5);

    // Stall holds everything and blocks the write; flush+stall gives a bubble.
    sw(32'h30, 32'hCAFEF00D);
    repeat (3)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h30, 32'h0BADBEEF, 1'b1, 1'b0, 1'b1);
    lw(32'h30, 5'd6);
    check_eq("stall_mem", out_MEM_WB_Read_Data, 32'hCAFEF00D);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h30, 32'h12345678, 1'b1, 1'b1, 1'b1);
    check_eq("flush_bubble", 32'(out_MEM_WB_Valid), 32'h0);
    lw(32'h30, 5'd6);
    check_eq("flush_mem", out_MEM_WB_Read_Data, 32'hCAFEF00D);

    // Read and write together returns the pre-write word.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h10, 32'h00000055, 1'b0, 1'b0, 1'b1);
    check_eq("rw_prewrite", out_MEM_WB_Read_Data, 32'hDEADBEEF);
    lw(32'h10, 5'd8);
    check_eq("rw_postwrite", out_MEM_WB_Read_Data, 32'h00000055);

    // Misaligned word store at 0x13.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h13, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
    check_eq("mis_flag", 32'(out_MEM_Misaligned), 32'(TRAP_EN));
    check_eq("mis_regwr", 32'(out_MEM_WB_Reg_Write), TRAP_EN ? 32'h0 : 32'h1);
    lw(32'h10, 5'd9);
    check_eq("mis_pulse_end", 32'(out_MEM_Misaligned), 32'h0);
    check_eq("mis_mem", out_MEM_WB_Read_Data, TRAP_EN ? 32'h00000055 : 32'hA5A5A5A5);

    // Random mix over a preloaded window.
    for (int i = 0; i < 8; i++) sw(32'h40 + 32'(i * 4), $urandom);
    for (int i = 0; i < 150; i++) begin
      op   = $urandom_range(0, 3);
      addr = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'({$urandom_range(0, 7), 10'b0});
      if (op == 1) addr = addr + 32'($urandom_range(0, 3));
      step(op == 1, op != 2, op >= 2, 1'($urandom), 1'($urandom), 5'($urandom),
           addr, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b1);
    end

    // Store counter wrap.
    start_count = state.count;
    n = 65536 - int'(start_count) + 3;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h60, 32'(i), 1'b0, 1'b0, 1'b0);
    check_eq("count_wrap", 32'(out_MEM_Store_Count), 32'd3);

    // Asynchronous reset in the middle of a store cycle.
    sw(32'h50, 32'h0F0F0F0F);
    in_MEM_Mem_Write = 1'b1; in_MEM_Mem_Read = 1'b0; in_MEM_Store_Byte = 1'b0;
    in_MEM_ALU_Result = 32'h50; in_MEM_Write_Data = 32'hFFFF0000;
    in_stall = 1'b0; in_flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_edge");
    rst_n = 1'b1;
    state = '{default: '0};
    lw(32'h50, 5'd10);
    check_eq("rst_no_store", out_MEM_WB_Read_Data, 32'h0F0F0F0F);
    check_eq("rst_count", 32'(out_MEM_Store_Count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
